// File: rtl/popcount_stream_if.sv
// Stream bundle between the deserializer, the popcount block and the count sink.
// Signal directions are named from the popcount block's side.
interface popcount_stream_if #(
  parameter int unsigned DATA_BUS_WIDTH = 16
);
  localparam int unsigned CNT_WIDTH = $clog2(DATA_BUS_WIDTH + 1);

  logic [DATA_BUS_WIDTH-1:0] data_i;
  logic                      data_val_i;
  logic                      data_ready_o;
  logic [CNT_WIDTH-1:0]      cnt_o;
  logic                      cnt_val_o;
  logic                      cnt_ready_i;

  // Popcount block side
  modport slave (
    input  data_i, data_val_i, cnt_ready_i,
    output data_ready_o, cnt_o, cnt_val_o
  );

  // Word source / count sink side
  modport master (
    output data_i, data_val_i, cnt_ready_i,
    input  data_ready_o, cnt_o, cnt_val_o
  );
endinterface

// File: rtl/popcount_stream.sv
// Streaming population counter: two-stage valid/ready pipeline.
// S1 registers 4-bit group popcounts, S2 registers their sum as the output count.
module popcount_stream #(
  parameter int unsigned DATA_BUS_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  popcount_stream_if.slave    bus
);
  localparam int unsigned CNT_WIDTH = $clog2(DATA_BUS_WIDTH + 1);
  localparam int unsigned NGROUPS   = (DATA_BUS_WIDTH + 3) / 4;
  localparam int unsigned PAD_W     = NGROUPS * 4;

  logic [PAD_W-1:0]     data_pad;
  logic [2:0]           grp_d [NGROUPS];
  logic [2:0]           grp_q [NGROUPS];
  logic [CNT_WIDTH-1:0] sum_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 v1_q;
  logic                 v2_q;
  logic                 adv1;
  logic                 adv2;
  logic                 in_xfer;

  // Top group is zero-padded when the width is not a multiple of four
  assign data_pad = PAD_W'(bus.data_i);

  // Pipeline advance: an empty stage always accepts, so bubbles collapse
  assign adv2    = ~v2_q | bus.cnt_ready_i;
  assign adv1    = ~v1_q | adv2;
  assign in_xfer = bus.data_val_i & adv1;

  assign bus.data_ready_o = adv1;
  assign bus.cnt_val_o    = v2_q;
  assign bus.cnt_o        = cnt_q;

  // Per-group popcount of the incoming word
  always_comb begin
    for (int unsigned g = 0; g < NGROUPS; g++) begin
      grp_d[g] = '0;
      for (int unsigned b = 0; b < 4; b++) begin
        grp_d[g] = grp_d[g] + 3'(data_pad[4*g+b]);
      end
    end
  end

  // Sum of the registered group counts; total never exceeds DATA_BUS_WIDTH
  always_comb begin
    sum_d = '0;
    for (int unsigned g = 0; g < NGROUPS; g++) begin
      sum_d = sum_d + CNT_WIDTH'(grp_q[g]);
    end
  end

  // Stage registers: S2 takes from S1 on adv2, S1 takes from the input on adv1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      grp_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          cnt_q <= sum_d;
        end
      end
      if (adv1) begin
        v1_q <= in_xfer;
        if (in_xfer) begin
          grp_q <= grp_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_popcount_stream.sv
// Self-checking bench for popcount_stream: directed cases plus a randomized
// throttled stream compared against a queue of $countones results.
module tb_popcount_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  popcount_stream_if #(.DATA_BUS_WIDTH(16)) bus ();
  popcount_stream_if #(.DATA_BUS_WIDTH(7))  bus7 ();

  popcount_stream #(.DATA_BUS_WIDTH(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  popcount_stream #(.DATA_BUS_WIDTH(7)) dut7 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus7.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int   exp_q[$];
  int   n_acc    = 0;
  logic stalled  = 1'b0;
  int   held_cnt = 0;

  logic       obs_val;
  logic       obs_rdy;
  logic [4:0] obs_cnt;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; samples between edges and runs the scoreboard
  task automatic step(input logic [15:0] d, input logic dv, input logic cr);
    @(negedge clk);
    bus.data_i      = d;
    bus.data_val_i  = dv;
    bus.cnt_ready_i = cr;
    #2;
    obs_val = bus.cnt_val_o;
    obs_cnt = bus.cnt_o;
    obs_rdy = bus.data_ready_o;
    check("ready", int'(obs_rdy), int'(exp_q.size() < 2 || cr));
    if (stalled) begin
      check("hold_val", int'(obs_val), 1);
      check("hold_cnt", int'(obs_cnt), held_cnt);
    end
    if (obs_val) begin
      if (exp_q.size() == 0) begin
        check("spurious_val", int'(obs_val), 0);
      end else begin
        check("cnt", int'(obs_cnt), exp_q[0]);
        if (cr) void'(exp_q.pop_front());
      end
    end
    stalled  = obs_val && !cr;
    held_cnt = int'(obs_cnt);
    if (dv && obs_rdy) begin
      exp_q.push_back($countones(d));
      n_acc++;
    end
  endtask

  initial begin
    logic [15:0] bb     [5] = '{16'h0000, 16'h0001, 16'h8001, 16'hAAAA, 16'hF0F0};
    int          bb_exp [5] = '{0, 1, 2, 8, 8};
    int          cyc;

    bus.data_i       = '0;
    bus.data_val_i   = 1'b0;
    bus.cnt_ready_i  = 1'b0;
    bus7.data_i      = '0;
    bus7.data_val_i  = 1'b0;
    bus7.cnt_ready_i = 1'b1;

    // Reset values
    #3;
    check("rst_val", int'(bus.cnt_val_o), 0);
    check("rst_cnt", int'(bus.cnt_o), 0);
    check("rst_rdy", int'(bus.data_ready_o), 1);
    @(negedge clk);
    rst = 1'b0;

    // Single word: visible exactly two cycles later, for one cycle
    step(16'hFFFF, 1'b1, 1'b1);
    step(16'h0000, 1'b0, 1'b1);
    check("single_early", int'(obs_val), 0);
    step(16'h0000, 1'b0, 1'b1);
    check("single_val", int'(obs_val), 1);
    check("single_cnt", int'(obs_cnt), 16);
    step(16'h0000, 1'b0, 1'b1);
    check("single_once", int'(obs_val), 0);

    // Back-to-back stream, no gaps
    for (int k = 0; k < 7; k++) begin
      if (k < 5) step(bb[k], 1'b1, 1'b1);
      else       step(16'h0000, 1'b0, 1'b1);
      if (k < 2) begin
        check("b2b_lead", int'(obs_val), 0);
      end else begin
        check("b2b_val", int'(obs_val), 1);
        check("b2b_cnt", int'(obs_cnt), bb_exp[k-2]);
      end
    end
    step(16'h0000, 1'b0, 1'b1);
    check("b2b_tail", int'(obs_val), 0);

    // Backpressure: two words fill the pipe, third waits for ready
    step(16'h0003, 1'b1, 1'b0);
    check("bp_acc1", int'(obs_rdy), 1);
    step(16'h0007, 1'b1, 1'b0);
    check("bp_acc2", int'(obs_rdy), 1);
    for (int k = 0; k < 3; k++) begin
      step(16'h000F, 1'b1, 1'b0);
      check("bp_full_rdy", int'(obs_rdy), 0);
      check("bp_hold_val", int'(obs_val), 1);
      check("bp_hold_cnt", int'(obs_cnt), 2);
    end
    step(16'h000F, 1'b1, 1'b1);
    check("bp_rel_rdy", int'(obs_rdy), 1);
    check("bp_out0", int'(obs_cnt), 2);
    step(16'h0000, 1'b0, 1'b1);
    check("bp_out1_val", int'(obs_val), 1);
    check("bp_out1", int'(obs_cnt), 3);
    step(16'h0000, 1'b0, 1'b1);
    check("bp_out2_val", int'(obs_val), 1);
    check("bp_out2", int'(obs_cnt), 4);
    step(16'h0000, 1'b0, 1'b1);
    check("bp_empty", int'(obs_val), 0);

    // Asynchronous reset between edges with the pipeline full
    step(16'h1234, 1'b1, 1'b0);
    step(16'h00FF, 1'b1, 1'b0);
    @(negedge clk);
    bus.data_val_i = 1'b0;
    #2;
    check("mid_full_val", int'(bus.cnt_val_o), 1);
    check("mid_full_rdy", int'(bus.data_ready_o), 0);
    rst = 1'b1;
    #1;
    check("mid_rst_val", int'(bus.cnt_val_o), 0);
    check("mid_rst_rdy", int'(bus.data_ready_o), 1);
    exp_q.delete();
    stalled = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(16'h0000, 1'b0, 1'b1);
      check("post_rst_quiet", int'(obs_val), 0);
    end

    // Randomly throttled stream against the reference queue
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      step(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc++;
    end
    check("rand_budget", int'(n_acc >= 10000), 1);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      step(16'($urandom), 1'b0, 1'b1);
      cyc++;
    end
    check("rand_drain", exp_q.size(), 0);

    // Width 7: zero-padded top group
    @(negedge clk);
    bus7.data_i     = 7'h7F;
    bus7.data_val_i = 1'b1;
    #2;
    check("w7_rdy", int'(bus7.data_ready_o), 1);
    @(negedge clk);
    bus7.data_i = 7'h55;
    @(negedge clk);
    bus7.data_val_i = 1'b0;
    #2;
    check("w7_val0", int'(bus7.cnt_val_o), 1);
    check("w7_cnt0", int'(bus7.cnt_o), 7);
    @(negedge clk);
    #2;
    check("w7_val1", int'(bus7.cnt_val_o), 1);
    check("w7_cnt1", int'(bus7.cnt_o), 4);
    @(negedge clk);
    #2;
    check("w7_idle", int'(bus7.cnt_val_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
